// File: rtl/mips_mem_arbiter.sv
`timescale 1ns/1ps
// mips_mem_arbiter
// Lets one word-addressed synchronous RAM serve three requesters: instruction
// fetch (IF), the data-memory stage (DM) and a debug/program loader (DBG).
// - Grants are combinational, and at most one is issued per cycle.
// - Read data is returned one cycle later to whichever port issued the read.
// - IF is protected from starvation under back-to-back DM traffic.
// - A debug lock sequence (RUN -> DRAIN -> LOCKED) keeps the core off the
//   memory while the loader owns it.
module mips_mem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          dm_req,
  input  logic [AW-1:0] dm_addr,
  input  logic          dm_we,
  input  logic [DW-1:0] dm_wdata,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  input  logic          dbg_we,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          if_gnt,
  output logic          dm_gnt,
  output logic          dbg_gnt,
  output logic          if_rvalid,
  output logic          dm_rvalid,
  output logic          dbg_rvalid,
  output logic [DW-1:0] rdata,
  output logic          cpu_hold,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

  // One bit per requester. The same bit positions are used for grants and
  // for the registered read-valid vector.
  localparam int P_IF  = 0;
  localparam int P_DM  = 1;
  localparam int P_DBG = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] if_wait_q, if_wait_d;
  logic [2:0]    rvalid_q, rvalid_d;

  logic          dbg_ok;
  logic          cpu_ok;
  logic          starved;
  logic [2:0]    grant;
  logic          mem_en_c;
  logic          mem_we_c;

  // Decide who may use the RAM this cycle. DBG is locked out only while a
  // CPU read drains. IF/DM are allowed only in RUN, and not in the cycle
  // where the lock request is first seen.
  always_comb begin
    dbg_ok  = (state_q != ST_DRAIN);
    cpu_ok  = (state_q == ST_RUN) && !dbg_lock;
    starved = (if_wait_q == WAIT_MAX);
    grant   = 3'b000;
    if (dbg_req && dbg_ok) begin
      grant[P_DBG] = 1'b1;
    end else if (cpu_ok) begin
      if (starved && if_req) begin
        grant[P_IF] = 1'b1;
      end else if (dm_req) begin
        grant[P_DM] = 1'b1;
      end else if (if_req) begin
        grant[P_IF] = 1'b1;
      end else begin
        grant = 3'b000;
      end
    end else begin
      grant = 3'b000;
    end
  end

  // Steer the winner's address/command onto the RAM port. IF never writes.
  always_comb begin
    mem_en_c  = 1'b0;
    mem_we_c  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      3'b001: begin
        mem_en_c = 1'b1;
        mem_we_c = 1'b0;
        mem_addr = if_addr;
      end
      3'b010: begin
        mem_en_c  = 1'b1;
        mem_we_c  = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      3'b100: begin
        mem_en_c  = 1'b1;
        mem_we_c  = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: begin
        mem_en_c  = 1'b0;
        mem_we_c  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  // Next values for the starvation counter, the read-owner tags and the lock FSM.
  always_comb begin
    if_wait_d = if_wait_q;
    rvalid_d  = 3'b000;
    state_d   = state_q;

    // Count consecutive IF denials, saturating at the limit. The count
    // clears on an IF grant or when IF stops asking.
    if (if_req && !grant[P_IF]) begin
      if (if_wait_q != WAIT_MAX) begin
        if_wait_d = if_wait_q + WW'(1);
      end else begin
        if_wait_d = if_wait_q;
      end
    end else begin
      if_wait_d = '0;
    end

    // Tag the owner of a granted read, so its data is returned next cycle.
    rvalid_d[P_IF]  = grant[P_IF];
    rvalid_d[P_DM]  = grant[P_DM]  & ~dm_we;
    rvalid_d[P_DBG] = grant[P_DBG] & ~dbg_we;

    // A CPU read accepted on the last edge is being returned now. In that
    // case the lock passes through one DRAIN cycle before LOCKED.
    case (state_q)
      ST_RUN: begin
        if (dbg_lock) begin
          if (rvalid_q[P_IF] || rvalid_q[P_DM]) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (dbg_lock) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, starvation counter and read-valid tags. Reset discards any
  // read that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      if_wait_q <= '0;
      rvalid_q  <= 3'b000;
    end else begin
      state_q   <= state_d;
      if_wait_q <= if_wait_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Grants, RAM strobes and the core stall are forced low while reset is
  // asserted, independent of the clock.
  assign if_gnt  = rst_n & grant[P_IF];
  assign dm_gnt  = rst_n & grant[P_DM];
  assign dbg_gnt = rst_n & grant[P_DBG];
  assign mem_en  = rst_n & mem_en_c;
  assign mem_we  = rst_n & mem_we_c;

  assign cpu_hold = rst_n & ((state_q != ST_RUN) | dbg_lock);

  assign if_rvalid  = rvalid_q[P_IF];
  assign dm_rvalid  = rvalid_q[P_DM];
  assign dbg_rvalid = rvalid_q[P_DBG];
  assign rdata      = (|rvalid_q) ? mem_rdata : '0;

endmodule
